// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM read arbiter: FSM states, default
// bus widths, tied-off control pin levels and the round-robin index helper.
package sram_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StDone
   } sram_rd_state_t;

   localparam int unsigned DefaultAw = 20;
   localparam int unsigned DefaultDw = 16;

   localparam logic CeTie = 1'b0;
   localparam logic UbTie = 1'b0;
   localparam logic LbTie = 1'b0;
   localparam logic WeTie = 1'b1;

   function automatic int unsigned rr_idx(input int unsigned ptr, input int unsigned k,
                                          input int unsigned n);
      return (ptr + k) % n;
   endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin selector: the first high request after the
// pointer position wins; purely combinational.
module sram_rr_pick
   import sram_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   localparam int unsigned PW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_winner,
   output logic            o_any
);

   logic [PW-1:0] w_idx;

   always_comb begin
      o_winner = '0;
      o_any    = 1'b0;
      w_idx    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         w_idx = PW'(rr_idx(32'(i_ptr), k, NREQ));
         if (!o_any && i_req[w_idx]) begin
            o_winner[w_idx] = 1'b1;
            o_any           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM read port between NREQ
// requesters; each read takes WAIT+2 cycles and the next grant may overlap DONE.
module sram_read_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = DefaultAw,
   parameter int unsigned DW   = DefaultDw,
   parameter int unsigned WAIT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ*AW-1:0] i_addr,
   output logic [NREQ-1:0]   o_gnt,
   output logic [NREQ-1:0]   o_rvalid,
   output logic [DW-1:0]     o_rdata,
   output logic              o_ce,
   output logic              o_ub,
   output logic              o_lb,
   output logic              o_we,
   output logic              o_oe,
   output logic [AW-1:0]     o_sram_addr,
   input  logic [DW-1:0]     i_data
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT) : 1;
   localparam logic [CW-1:0] WaitLoad = CW'(WAIT - 1);
   localparam logic [PW-1:0] PtrRst   = PW'(NREQ - 1);

   if (WAIT == 0) begin : g_wait_chk
      $error("sram_read_arbiter: WAIT must be at least 1");
   end

   sram_rd_state_t r_state, w_state_d;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_owner, r_ptr, w_pick_ptr, w_win_idx;
   logic [AW-1:0]   r_sram_addr, w_addr_sel;
   logic [DW-1:0]   r_rdata;
   logic [NREQ-1:0] w_winner;
   logic            w_any, w_arb, w_grant;

   // DONE arbitrates against the just-finished owner, not the stale pointer.
   assign w_pick_ptr = (r_state == StDone) ? r_owner : r_ptr;

   sram_rr_pick #(
      .NREQ(NREQ)
   ) u_pick (
      .i_req   (i_req),
      .i_ptr   (w_pick_ptr),
      .o_winner(w_winner),
      .o_any   (w_any)
   );

   always_comb begin
      w_win_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_winner[i]) w_win_idx = PW'(i);
      end
   end

   assign w_addr_sel = i_addr[32'(w_win_idx) * AW +: AW];

   always_comb begin
      w_state_d = r_state;
      w_arb     = 1'b0;
      o_gnt     = '0;
      o_rvalid  = '0;
      o_oe      = 1'b1;
      unique case (r_state)
         StIdle:   w_arb = 1'b1;
         StSetup:  w_state_d = StStrobe;
         StStrobe: begin
            o_oe = 1'b0;
            if (r_cnt == '0) w_state_d = StDone;
         end
         StDone: begin
            o_rvalid[r_owner] = 1'b1;
            w_arb             = 1'b1;
         end
         default:  w_state_d = StIdle;
      endcase
      // Gate with reset so no grant leaks out while reset is held.
      w_grant = w_arb && w_any && i_rst_n;
      if (w_arb) w_state_d = w_any ? StSetup : StIdle;
      if (w_grant) o_gnt = w_winner;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_owner     <= '0;
         r_ptr       <= PtrRst;
         r_sram_addr <= '0;
         r_rdata     <= '0;
      end else begin
         r_state <= w_state_d;
         if (r_state == StSetup) begin
            r_cnt <= WaitLoad;
         end else if (r_state == StStrobe && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (r_state == StStrobe && r_cnt == '0) r_rdata <= i_data;
         if (r_state == StDone) r_ptr <= r_owner;
         if (w_grant) begin
            r_owner     <= w_win_idx;
            r_sram_addr <= w_addr_sel;
         end
      end
   end

   assign o_rdata     = r_rdata;
   assign o_sram_addr = r_sram_addr;
   assign o_ce        = CeTie;
   assign o_ub        = UbTie;
   assign o_lb        = LbTie;
   assign o_we        = WeTie;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: directed phases with random addresses and
// requests, checked every cycle against a transaction-level reference model.
module tb_sram_read_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 20;
   localparam int unsigned DW   = 16;
   localparam int unsigned WAIT = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req;
   logic [NREQ*AW-1:0]   addr;
   logic [NREQ-1:0]      gnt, rvalid;
   logic [DW-1:0]        rdata, data;
   logic                 ce, ub, lb, we, oe;
   logic [AW-1:0]        sram_addr;
   logic [63:0]          addr_rnd;

   // Reference model state
   int                   cyc, next_free, fl_t, fl_port, ptr;
   logic                 fl_valid;
   logic [AW-1:0]        m_addr;
   logic [DW-1:0]        m_rdata;
   bit                   capmode;
   logic [NREQ-1:0]      drop_flag, drop_now;
   int                   n_vec, n_err;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a, input logic [31:0] c,
                                               input bit cm);
      logic [DW-1:0] v;
      if (a == 20'h00010) v = 16'hBEEF;
      else v = (a[15:0] * 16'h9E37) ^ {a[19:16], 12'h5A3};
      if (cm) v = v ^ {c[7:0], ~c[7:0]};
      return v;
   endfunction

   assign data = sram_word(sram_addr, 32'(cyc), capmode);

   sram_read_arbiter #(
      .NREQ(NREQ),
      .AW  (AW),
      .DW  (DW),
      .WAIT(WAIT)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_addr     (addr),
      .o_gnt      (gnt),
      .o_rvalid   (rvalid),
      .o_rdata    (rdata),
      .o_ce       (ce),
      .o_ub       (ub),
      .o_lb       (lb),
      .o_we       (we),
      .o_oe       (oe),
      .o_sram_addr(sram_addr),
      .i_data     (data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_addr    = '0;
      m_rdata   = '0;
      fl_valid  = 1'b0;
      ptr       = NREQ - 1;
      next_free = 0;
      drop_now  = '0;
   endtask

   function automatic bit in_strobe();
      return fl_valid && cyc >= fl_t + 2 && cyc <= fl_t + 1 + int'(WAIT);
   endfunction

   // Compare this cycle's outputs with the model, then advance the model
   // to what the coming rising edge should do.
   task automatic check_cycle();
      logic [NREQ-1:0] e_gnt, e_rv;
      logic            e_oe;
      int              w;
      e_gnt = '0;
      e_rv  = '0;
      w     = -1;
      if (rst_n) begin
         if (cyc >= next_free) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
               if (w < 0 && req[(ptr + k) % int'(NREQ)]) w = (ptr + k) % int'(NREQ);
            end
         end
         if (w >= 0) e_gnt[w] = 1'b1;
         if (fl_valid && cyc == fl_t + int'(WAIT) + 2) e_rv[fl_port] = 1'b1;
      end
      e_oe = !(rst_n && in_strobe());
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rvalid", 32'(rvalid), 32'(e_rv));
      chk("oe", 32'(oe), 32'(e_oe));
      chk("sram_addr", 32'(sram_addr), 32'(m_addr));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("ties", 32'({ce, ub, lb, we}), 32'(4'b0001));
      if (rst_n) begin
         if (fl_valid && cyc == fl_t + 1 + int'(WAIT)) m_rdata = sram_word(m_addr, 32'(cyc), capmode);
         if (fl_valid && cyc == fl_t + int'(WAIT) + 2) fl_valid = 1'b0;
         if (w >= 0) begin
            fl_valid  = 1'b1;
            fl_port   = w;
            fl_t      = cyc;
            m_addr    = addr[w*AW +: AW];
            ptr       = w;
            next_free = cyc + int'(WAIT) + 2;
            if (drop_flag[w]) drop_now[w] = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      cyc++;
      req      = req & ~drop_now;
      drop_now = '0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rand_addr();
      addr_rnd = {$urandom(), $urandom()};
      addr     = addr_rnd[NREQ*AW-1:0];
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      cyc       = 0;
      fl_t      = 0;
      fl_port   = 0;
      capmode   = 1'b0;
      drop_flag = '0;
      rst_n     = 1'b0;
      req       = '0;
      addr      = '0;
      model_reset();
      #1;
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_rvalid", 32'(rvalid), 32'(0));
      chk("rst_oe", 32'(oe), 32'(1));
      chk("rst_addr", 32'(sram_addr), 32'(0));
      chk("rst_rdata", 32'(rdata), 32'(0));
      run(2);
      rst_n = 1'b1;

      // Single read of 0x00010 from port 0, request withdrawn after its grant
      drop_flag = 2'b01;
      addr      = {20'h00000, 20'h00010};
      req       = 2'b01;
      run(WAIT + 4);
      chk("single_rdata", 32'(rdata), 32'(16'hBEEF));

      // Reset in the middle of a read
      req = 2'b01;
      for (int i = 0; i < 20 && !in_strobe(); i++) step();
      #1 rst_n = 1'b0;
      #1;
      chk("async_oe", 32'(oe), 32'(1));
      chk("async_addr", 32'(sram_addr), 32'(0));
      chk("async_rdata", 32'(rdata), 32'(0));
      chk("async_rvalid", 32'(rvalid), 32'(0));
      model_reset();
      run(2);
      rst_n = 1'b1;
      addr  = {20'h00000, 20'h00020};
      req   = 2'b01;
      run(WAIT + 4);

      // Contention: both ports held high
      drop_flag = '0;
      req       = 2'b11;
      for (int i = 0; i < 40; i++) begin
         rand_addr();
         step();
      end
      req = '0;
      run(WAIT + 3);

      // Lone requester on port 1
      req = 2'b10;
      for (int i = 0; i < 24; i++) begin
         rand_addr();
         step();
      end
      req = '0;
      run(WAIT + 3);

      // Dropped request with the other port competing later
      drop_flag = 2'b01;
      req       = 2'b01;
      rand_addr();
      run(2);
      req[1] = 1'b1;
      run(2 * (WAIT + 2) + 2);
      req = '0;
      run(WAIT + 3);

      // Capture point: data bus changes every cycle
      capmode   = 1'b1;
      drop_flag = '0;
      req       = 2'b11;
      for (int i = 0; i < 30; i++) begin
         rand_addr();
         step();
      end

      // Random traffic: requests held until granted, random withdrawal
      for (int i = 0; i < 200; i++) begin
         rand_addr();
         capmode   = ($urandom_range(0, 1) == 1);
         drop_flag = NREQ'($urandom());
         for (int p = 0; p < int'(NREQ); p++) begin
            if (!req[p] && $urandom_range(0, 2) == 0) req[p] = 1'b1;
         end
         step();
      end
      req = '0;
      run(WAIT + 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_read_arbiter.md
# sram_read_arbiter

Shares the single off-chip SRAM read port between several requesters, e.g. the background line fetch and the sprite fetch. Requesters see a per-port req/gnt/rvalid handshake. The block drives the SRAM control pins and address directly and captures read data after a fixed number of OE-low cycles. Arbitration is round-robin, and a new read can be granted in the completion cycle of the previous one.

## Interface
- NREQ, 2: number of requesters (2..8).
- AW, 20: SRAM word-address width.
- DW, 16: SRAM data width.
- WAIT, 2: OE-low cycles before capture; minimum 1, and WAIT=0 fails elaboration.
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester read request, level, held until gnt.
- addr  in  NREQ*AW  packed request addresses; port i uses bits [i*AW +: AW].
- gnt  out  NREQ  one-hot, one-cycle pulse; addr[i] is sampled in this cycle.
- rvalid  out  NREQ  one-hot, one-cycle pulse; rdata is valid for port i.
- rdata  out  DW  last captured read word, held until the next capture.
- CE, UB, LB  out  1 each  tied 0.
- WE  out  1  tied 1 (read-only).
- OE  out  1  active-low output enable.
- ADDR  out  AW  registered SRAM address.
- Data  in  DW  SRAM data bus.

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: if any req is high, pick a winner, pulse gnt[winner] combinationally, latch addr[winner] into ADDR and the owner register, then go to SETUP. Otherwise stay in IDLE.
- SETUP: OE=1, ADDR stable. Load the wait counter with WAIT-1, then go to STROBE.
- STROBE: OE=0. The counter decrements each cycle. In the cycle the counter equals 0, capture Data into rdata and go to DONE.
- DONE: rvalid[owner]=1, OE=1, and the pointer is set to owner. Arbitration then runs exactly as in IDLE using the updated pointer.
  - With a winner: gnt pulses and the block goes to SETUP.
  - With no winner: go to IDLE.
- Round-robin: search starts at (pointer+1) mod NREQ and takes the first high req.
- A requester dropping req after its gnt does not cancel the read; rvalid is still issued.
- A requester that wants a second read keeps req high; it is re-granted only in its round-robin turn.
- Reset values:
  - state=IDLE, pointer=NREQ-1 (port 0 has first priority).
  - gnt=0, rvalid=0, rdata=0, ADDR=0, OE=1.
  - CE/UB/LB=0, WE=1.
- Reset asserted mid-read: outputs take reset values immediately (asynchronously). The aborted read never produces rvalid.

## Timing
- gnt in cycle t. ADDR holds the new address from t+1.
- OE is low in cycles t+2 .. t+1+WAIT.
- Capture happens on the edge ending t+1+WAIT.
- rvalid and new rdata appear in cycle t+2+WAIT; latency gnt→rvalid is WAIT+2.
- Sustained throughput is one read per WAIT+2 cycles, since the next gnt can coincide with DONE.
- No gnt is issued in SETUP or STROBE, and at most one gnt and one rvalid are asserted per cycle.
- Simultaneous rvalid[i] and gnt[j] in DONE is legal; i==j is allowed.

## Structure
- Shared package sram_pkg holds:
  - the state enum (sram_rd_state_t);
  - default AW/DW constants;
  - the tied-off control values (CE/UB/LB=0, WE=1).
- One sub-module, sram_rr_pick: combinational round-robin selector. Inputs are req[NREQ] and pointer; outputs are a one-hot winner and an any flag. It holds no state.
- The top module contains the FSM, wait counter, owner/pointer registers, ADDR register and rdata register.

## Test plan
- **Single read:** WAIT=2, req[0]=1, addr0=0x00010, SRAM model returns 0xBEEF at that address.
  - gnt[0] at t and ADDR=0x00010 at t+1.
  - OE low at t+2 and t+3.
  - rvalid[0] with rdata=0xBEEF at t+4.
- **Contention from reset:** req[0] and req[1] held high continuously.
  - Grants alternate 0,1,0,1, with gnt pulses 4 cycles apart.
  - Each rvalid matches its port's address data.
- **Lone requester:** only req[1] held high.
  - gnt[1] every WAIT+2 cycles; gnt[0] and rvalid[0] never assert.
- **Reset mid-read:** Reset driven low during STROBE.
  - OE=1, ADDR=0, rdata=0 without waiting for a clock edge.
  - No rvalid after release.
  - A subsequent req[0] is granted first and completes normally.
- **Dropped request:** req[0] deasserted in the cycle after gnt[0].
  - rvalid[0] still appears at t+WAIT+2; no second gnt[0].
- **Capture point:** Data changes every cycle while OE is low.
  - rdata equals the value present in the last STROBE cycle (t+1+WAIT).
